// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the two-port ALU arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface alu_arbiter_if;
    logic       req0_valid;
    logic [2:0] req0_op;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic       req0_ready;
    logic       rsp0_valid;

    logic       req1_valid;
    logic [2:0] req1_op;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic       req1_ready;
    logic       rsp1_valid;

    logic [7:0] rsp_data;
    logic       rsp_zero;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_y;

    logic       busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_y,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_data, rsp_zero, alu_a, alu_b, alu_op, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_y,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_data, rsp_zero, alu_a, alu_b, alu_op, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational 8-bit ALU between two requesters: round-robin grant,
// operands held for ALU_LAT cycles, result captured and pulsed back to the owner.
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic [3:0] LAST_CNT = 4'(ALU_LAT - 1);

    logic [1:0] state_reg;
    logic       last_grant_reg;
    logic       owner_reg;
    logic [3:0] cnt_reg;
    logic [7:0] alu_a_reg;
    logic [7:0] alu_b_reg;
    logic [2:0] alu_op_reg;
    logic [7:0] rsp_data_reg;
    logic       rsp_zero_reg;

    logic       grant_sel;
    logic       idle;
    logic       handshake;

    assign idle = (state_reg == ST_IDLE);

    // On a tie the pointer hands the grant to whoever did not win last time;
    // a lone requester always wins regardless of the pointer.
    always_comb begin
        grant_sel = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_sel = ~last_grant_reg;
        end else if (bus.req1_valid) begin
            grant_sel = 1'b1;
        end
    end

    assign handshake = idle && (grant_sel ? bus.req1_valid : bus.req0_valid);

    assign bus.req0_ready = rst_n && idle && bus.req0_valid && (grant_sel == 1'b0);
    assign bus.req1_ready = rst_n && idle && bus.req1_valid && (grant_sel == 1'b1);

    assign bus.rsp0_valid = (state_reg == ST_RESP) && (owner_reg == 1'b0);
    assign bus.rsp1_valid = (state_reg == ST_RESP) && (owner_reg == 1'b1);

    assign bus.busy     = !idle;
    assign bus.alu_a    = alu_a_reg;
    assign bus.alu_b    = alu_b_reg;
    assign bus.alu_op   = alu_op_reg;
    assign bus.rsp_data = rsp_data_reg;
    assign bus.rsp_zero = rsp_zero_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            cnt_reg        <= 4'd0;
            alu_a_reg      <= 8'h00;
            alu_b_reg      <= 8'h00;
            alu_op_reg     <= 3'b000;
            rsp_data_reg   <= 8'h00;
            rsp_zero_reg   <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (handshake) begin
                        alu_a_reg      <= grant_sel ? bus.req1_a  : bus.req0_a;
                        alu_b_reg      <= grant_sel ? bus.req1_b  : bus.req0_b;
                        alu_op_reg     <= grant_sel ? bus.req1_op : bus.req0_op;
                        owner_reg      <= grant_sel;
                        last_grant_reg <= grant_sel;
                        cnt_reg        <= 4'd0;
                        state_reg      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Sample only after the operands have settled for ALU_LAT cycles.
                    if (cnt_reg == LAST_CNT) begin
                        rsp_data_reg <= bus.alu_y;
                        rsp_zero_reg <= (bus.alu_y == 8'h00);
                        state_reg    <= ST_RESP;
                    end
                    cnt_reg <= cnt_reg + 4'd1;
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
